// File: rtl/cpld_iowr_capture.sv
// cpld_iowr_capture: filters Z80 IOWR cycles to &7FXX and stages the bank/mode
// byte, committing it to the mapper only while no memory cycle is running.
module cpld_iowr_capture #(
  parameter int FILTER_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       iorq_b,
  input  logic       wr_b,
  input  logic       adr15,
  input  logic       mreq_b,
  input  logic [7:0] data,
  output logic [5:0] ramblock,
  output logic       pending,
  output logic       cfg_strobe,
  output logic       overrun
);
  localparam logic [2:0] FC = 3'(FILTER_CYCLES);
  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;
  state_t     state;
  logic [2:0] cnt;
  logic [5:0] pending_q;
  logic       s_iorq_b, s_wr_b, s_adr15, s_mreq_b;
  logic [7:0] s_data;
  logic       hit, cap, commit;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      s_iorq_b <= 1'b1;
      s_wr_b   <= 1'b1;
      s_adr15  <= 1'b1;
      s_mreq_b <= 1'b1;
      s_data   <= 8'h00;
    end else begin
      s_iorq_b <= iorq_b;
      s_wr_b   <= wr_b;
      s_adr15  <= adr15;
      s_mreq_b <= mreq_b;
      s_data   <= data;
    end
  assign hit    = !s_iorq_b && !s_wr_b && !s_adr15 && (s_data[7:6] == 2'b11);
  assign commit = pending && s_mreq_b;
  assign cap    = hit && ((state == IDLE && FC == 3'd1) || (state == QUAL && cnt + 3'd1 == FC));
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          state <= cap ? HOLD : QUAL;
          cnt   <= cap ? 3'd0 : 3'd1;
        end
        QUAL: if (!hit || cap) begin
          state <= hit ? HOLD : IDLE;
          cnt   <= 3'd0;
        end else cnt <= cnt + 3'd1;
        HOLD: if (s_iorq_b || s_wr_b) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // A commit takes the pre-edge pending_q, so a same-edge capture is never an overrun.
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      pending_q  <= 6'd0;
      pending    <= 1'b0;
      ramblock   <= 6'd0;
      cfg_strobe <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cfg_strobe <= commit;
      pending    <= cap || (pending && !commit);
      if (commit) ramblock <= pending_q;
      if (cap) pending_q <= s_data[5:0];
      if (cap && pending && !commit) overrun <= 1'b1;
    end
endmodule
